// File: rtl/adder_seq_ctrl.sv
// Byte-serial add/subtract sequencer: one 8-bit ripple slice processes
// NBYTES lanes LSB first, chaining carries through a carry register.
module adder_seq_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry_reg;
  logic [IDXW-1:0] idx;

  logic            accept_c, last_c;
  logic [7:0]      a_byte_c, b_byte_c, sum_c;
  logic [8:0]      cy_c;

  // Select the active byte lane of each operand
  always_comb begin
    a_byte_c = 8'h00;
    b_byte_c = 8'h00;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (idx == IDXW'(i)) begin
        a_byte_c = a_reg[i*8 +: 8];
        b_byte_c = b_reg[i*8 +: 8];
      end
    end
  end

  // 8-bit full-adder chain with carry-in at bit 0
  always_comb begin
    cy_c[0] = carry_reg;
    for (int i = 0; i < 8; i++) begin
      sum_c[i]  = a_byte_c[i] ^ b_byte_c[i] ^ cy_c[i];
      cy_c[i+1] = (a_byte_c[i] & b_byte_c[i]) | (cy_c[i] & (a_byte_c[i] ^ b_byte_c[i]));
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    last_c     = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_c) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Handshake flags track the upcoming state so they stay registered
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Operand capture, byte-serial datapath and flag generation
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept_c) begin
      a_reg     <= op_a;
      b_reg     <= sub ? ~op_b : op_b;
      carry_reg <= sub;
      idx       <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (idx == IDXW'(i)) result[i*8 +: 8] <= sum_c;
      end
      carry_reg <= cy_c[8];
      idx       <= idx + IDXW'(1);
      if (last_c) begin
        carry_out <= cy_c[8];
        overflow  <= (a_reg[W-1] == b_reg[W-1]) && (sum_c[7] != a_reg[W-1]);
      end
    end
  end

endmodule
